// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci controller and datapath:
// ALU opcodes and register-file addresses.
package fibo_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_DEC  = 3'b011,
        OP_INC  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_CLR  = 3'b111
    } alu_op_e;

    localparam logic [1:0] REG_R0 = 2'd0;
    localparam logic [1:0] REG_R1 = 2'd1;
    localparam logic [1:0] REG_R2 = 2'd2;
    localparam logic [1:0] REG_R3 = 2'd3;

endpackage

// File: rtl/fibo_alu.sv
// Combinational ALU for the Fibonacci datapath; arithmetic is done one bit
// wider so the top bit carries the carry-out or borrow.
module fibo_alu
    import fibo_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [2:0]      op,
    output logic [SIZE-1:0] result,
    output logic            carry
);

    logic [SIZE:0] wide;

    // Logic ops leave the top bit at zero, so carry is only ever set by arithmetic.
    always_comb begin
        wide = '0;
        case (op)
            OP_PASS: wide = {1'b0, a};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_DEC:  wide = {1'b0, a} - (SIZE+1)'(1);
            OP_INC:  wide = {1'b0, a} + (SIZE+1)'(1);
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_CLR:  wide = '0;
            default: wide = '0;
        endcase
        result = wide[SIZE-1:0];
        carry  = wide[SIZE];
    end

endmodule

// File: rtl/fibo_datapath.sv
// Register file, ALU and flag/output registers executing the Fibonacci
// controller's control words.
module fibo_datapath
    import fibo_pkg::*;
#(
    parameter int         SIZE     = 8,
    parameter logic [1:0] OUT_ADDR = 2'd3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [2:0]      alu_opcode,
    input  logic [1:0]      rd_addr1,
    input  logic [1:0]      rd_addr2,
    input  logic [1:0]      wrt_addr,
    input  logic            wrt_en,
    input  logic            load_data,
    input  logic [SIZE-1:0] DATA_IN,
    output logic            ZERO_FLAG,
    output logic            CARRY_FLAG,
    output logic [SIZE-1:0] RESULT,
    output logic            RESULT_VALID
);

    logic [SIZE-1:0] regs [4];
    logic [SIZE-1:0] alu_result;
    logic            alu_carry;
    logic            write;
    logic [SIZE-1:0] write_data;

    fibo_alu #(.SIZE(SIZE)) alu (
        .a      (regs[rd_addr1]),
        .b      (regs[rd_addr2]),
        .op     (alu_opcode),
        .result (alu_result),
        .carry  (alu_carry)
    );

    assign write      = wrt_en | load_data;
    assign write_data = load_data ? DATA_IN : alu_result;

    // Reads see pre-edge contents, which gives read-modify-write for free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (write) begin
            regs[wrt_addr] <= write_data;
        end
    end

    // Carry is sticky across ALU writes and only a load clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ZERO_FLAG    <= 1'b0;
            CARRY_FLAG   <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
        end else begin
            RESULT_VALID <= write && (wrt_addr == OUT_ADDR);
            if (write) begin
                ZERO_FLAG <= (write_data == '0);
                if (load_data)
                    CARRY_FLAG <= 1'b0;
                else if (alu_carry)
                    CARRY_FLAG <= 1'b1;
                if (wrt_addr == OUT_ADDR)
                    RESULT <= write_data;
            end
        end
    end

endmodule

// File: tb/tb_fibo_datapath.sv
// Self-checking bench for fibo_datapath: directed scenarios plus random
// control words checked against an integer-arithmetic reference model.
module tb_fibo_datapath;

    localparam int SIZE = 8;
    localparam int MODV = 1 << SIZE;

    localparam logic [2:0] PASS = 3'b000, ADD = 3'b001, SUB = 3'b010, DEC = 3'b011;
    localparam logic [2:0] INC = 3'b100, ANDO = 3'b101, ORO = 3'b110, CLR = 3'b111;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [2:0]      alu_opcode = '0;
    logic [1:0]      rd_addr1 = '0;
    logic [1:0]      rd_addr2 = '0;
    logic [1:0]      wrt_addr = '0;
    logic            wrt_en = 1'b0;
    logic            load_data = 1'b0;
    logic [SIZE-1:0] DATA_IN = '0;
    logic            ZERO_FLAG;
    logic            CARRY_FLAG;
    logic [SIZE-1:0] RESULT;
    logic            RESULT_VALID;

    int n_cmp = 0;
    int n_err = 0;

    int m_regs [4];
    int m_result;
    bit m_zero, m_carry, m_valid;

    fibo_datapath #(.SIZE(SIZE), .OUT_ADDR(2'd3)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .alu_opcode   (alu_opcode),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .wrt_addr     (wrt_addr),
        .wrt_en       (wrt_en),
        .load_data    (load_data),
        .DATA_IN      (DATA_IN),
        .ZERO_FLAG    (ZERO_FLAG),
        .CARRY_FLAG   (CARRY_FLAG),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_result = 0;
        m_zero = 0;
        m_carry = 0;
        m_valid = 0;
    endtask

    // Drive one control word after the falling edge, clock it in, advance
    // the model, and leave the caller 1 time unit after the rising edge.
    task automatic step(input logic [2:0] op, input int a1, input int a2, input int wa,
                        input bit we, input bit ld, input int din);
        int a, b, r, wd;
        bit c;
        @(negedge CLK);
        alu_opcode = op;
        rd_addr1 = 2'(a1);
        rd_addr2 = 2'(a2);
        wrt_addr = 2'(wa);
        wrt_en = we;
        load_data = ld;
        DATA_IN = 8'(din);
        a = m_regs[a1];
        b = m_regs[a2];
        c = 0;
        case (op)
            PASS: r = a;
            ADD:  begin r = (a + b) % MODV; c = (a + b) >= MODV; end
            SUB:  begin r = (a - b + MODV) % MODV; c = a < b; end
            DEC:  begin r = (a + MODV - 1) % MODV; c = (a == 0); end
            INC:  begin r = (a + 1) % MODV; c = (a == MODV - 1); end
            ANDO: r = a & b;
            ORO:  r = a | b;
            default: r = 0;
        endcase
        @(posedge CLK);
        m_valid = 0;
        if (we || ld) begin
            wd = ld ? (din % MODV) : r;
            m_regs[wa] = wd;
            m_zero = (wd == 0);
            if (ld) m_carry = 0;
            else if (c) m_carry = 1;
            if (wa == 3) begin
                m_result = wd;
                m_valid = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({ZERO_FLAG, CARRY_FLAG, RESULT_VALID} !== 3'b000 || RESULT !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got z=%b c=%b v=%b r=%0d, need all 0",
                     ZERO_FLAG, CARRY_FLAG, RESULT_VALID, RESULT);
        end
        RST = 1'b0;
    endtask

    task automatic test_loads();
        bit exp_zero [3] = '{1'b0, 1'b1, 1'b0};
        int vals [3] = '{5, 0, 1};
        for (int i = 0; i < 3; i++) begin
            step(PASS, 0, 0, i, 0, 1, vals[i]);
            n_cmp++;
            if (ZERO_FLAG !== exp_zero[i] || CARRY_FLAG !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL load_flags[%0d]: got z=%b c=%b, need z=%b c=0",
                         i, ZERO_FLAG, CARRY_FLAG, exp_zero[i]);
            end
        end
    endtask

    task automatic test_fibonacci();
        int seq [5] = '{1, 2, 3, 5, 8};
        for (int i = 0; i < 5; i++) begin
            step(ADD, 1, 2, 3, 1, 0, 0);
            n_cmp++;
            if (RESULT !== 8'(seq[i]) || RESULT_VALID !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL fib_result[%0d]: got %0d v=%b, need %0d v=1",
                         i, RESULT, RESULT_VALID, seq[i]);
            end
            step(PASS, 2, 0, 1, 1, 0, 0);
            n_cmp++;
            if (RESULT_VALID !== 1'b0 || RESULT !== 8'(seq[i])) begin
                n_err++;
                $display("[TB] FAIL fib_strobe[%0d]: got v=%b r=%0d, need v=0 r=%0d",
                         i, RESULT_VALID, RESULT, seq[i]);
            end
            step(PASS, 3, 0, 2, 1, 0, 0);
        end
    endtask

    task automatic test_counter();
        bit exp_zero [3] = '{1'b0, 1'b1, 1'b0};
        step(PASS, 0, 0, 0, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            step(DEC, 0, 0, 0, 1, 0, 0);
            n_cmp++;
            if (ZERO_FLAG !== exp_zero[i]) begin
                n_err++;
                $display("[TB] FAIL dec_zero[%0d]: got %b, need %b", i, ZERO_FLAG, exp_zero[i]);
            end
        end
        n_cmp++;
        if (CARRY_FLAG !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL dec_borrow: got %b, need 1", CARRY_FLAG);
        end
        step(PASS, 0, 0, 3, 1, 0, 0);
        n_cmp++;
        if (RESULT !== 8'd255) begin
            n_err++;
            $display("[TB] FAIL dec_wrap: got %0d, need 255", RESULT);
        end
    endtask

    task automatic test_overflow();
        step(PASS, 0, 0, 1, 0, 1, 200);
        step(PASS, 0, 0, 2, 0, 1, 100);
        step(ADD, 1, 2, 3, 1, 0, 0);
        n_cmp++;
        if (RESULT !== 8'd44 || CARRY_FLAG !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL add_overflow: got r=%0d c=%b, need r=44 c=1", RESULT, CARRY_FLAG);
        end
        step(PASS, 1, 0, 0, 1, 0, 0);
        n_cmp++;
        if (CARRY_FLAG !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL carry_sticky: got %b, need 1", CARRY_FLAG);
        end
        step(PASS, 0, 0, 0, 0, 1, 9);
        n_cmp++;
        if (CARRY_FLAG !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL carry_load_clear: got %b, need 0", CARRY_FLAG);
        end
    endtask

    task automatic test_priority_hold();
        logic [7:0] held;
        step(ADD, 1, 2, 3, 1, 1, 8'h7F);
        n_cmp++;
        if (RESULT !== 8'h7F || RESULT_VALID !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL load_priority: got r=%0h v=%b, need r=7f v=1", RESULT, RESULT_VALID);
        end
        held = RESULT;
        for (int i = 0; i < 3; i++) begin
            step(3'($urandom_range(7)), $urandom_range(3), $urandom_range(3), 3, 0, 0, $urandom);
            n_cmp++;
            if (RESULT !== held || RESULT_VALID !== 1'b0 || ZERO_FLAG !== 1'b0 || CARRY_FLAG !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL idle_hold[%0d]: got r=%0h v=%b z=%b c=%b, need r=%0h v=0 z=0 c=0",
                         i, RESULT, RESULT_VALID, ZERO_FLAG, CARRY_FLAG, held);
            end
        end
        step(PASS, 3, 0, 3, 1, 0, 0);
        n_cmp++;
        if (RESULT !== 8'h7F) begin
            n_err++;
            $display("[TB] FAIL idle_reg_hold: got %0h, need 7f", RESULT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(7)), $urandom_range(3), $urandom_range(3), $urandom_range(3),
                 ($urandom_range(3) != 0), ($urandom_range(4) == 0), $urandom_range(255));
            n_cmp++;
            if (RESULT !== 8'(m_result) || RESULT_VALID !== m_valid ||
                ZERO_FLAG !== m_zero || CARRY_FLAG !== m_carry) begin
                n_err++;
                $display("[TB] FAIL random[%0d]: got r=%0d v=%b z=%b c=%b, need r=%0d v=%b z=%b c=%b",
                         i, RESULT, RESULT_VALID, ZERO_FLAG, CARRY_FLAG,
                         m_result, m_valid, m_zero, m_carry);
            end
        end
    endtask

    task automatic test_midrun_reset();
        step(PASS, 0, 0, 1, 0, 1, 3);
        step(PASS, 0, 0, 2, 0, 1, 4);
        step(ADD, 1, 2, 3, 1, 0, 0);
        step(PASS, 2, 0, 1, 1, 0, 0);
        @(negedge CLK);
        alu_opcode = ADD;
        rd_addr1 = 2'd1;
        rd_addr2 = 2'd2;
        wrt_addr = 2'd3;
        wrt_en = 1'b1;
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({ZERO_FLAG, CARRY_FLAG, RESULT_VALID} !== 3'b000 || RESULT !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL async_reset: got z=%b c=%b v=%b r=%0d, need all 0",
                     ZERO_FLAG, CARRY_FLAG, RESULT_VALID, RESULT);
        end
        model_reset();
        @(posedge CLK);
        #1;
        n_cmp++;
        if (RESULT_VALID !== 1'b0 || RESULT !== 8'd0) begin
            n_err++;
            $display("[TB] FAIL reset_write_discard: got v=%b r=%0d, need v=0 r=0", RESULT_VALID, RESULT);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(ORO, i, i, 3, 1, 0, 0);
            n_cmp++;
            if (RESULT !== 8'd0 || ZERO_FLAG !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL reg_after_reset[%0d]: got r=%0d z=%b, need r=0 z=1", i, RESULT, ZERO_FLAG);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_fibonacci();
        test_counter();
        test_overflow();
        test_priority_hold();
        test_random();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
